axil_reg_slave: RTL and testbench

AXI-Lite responder register file that sits on one master-side port of the bus interconnect (m1/m2) and terminates its write and read transactions. Holds NUM_REGS word registers with byte-strobe writes and single-cycle read return. Reports out-of-range or unaligned accesses with DECERR. Exposes all register contents as a flat output for downstream control logic.

---
 rtl/axil_reg_slave.sv | 256 +++++++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// AXI-Lite responder: NUM_REGS byte-strobed word registers, DECERR for bad addresses.
// Optional AXIL_REG_SLAVE_ERR_CNT_EN adds a 16-bit saturating DECERR counter right after the last register.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_REGS   = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]          s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [RESP_WIDTH-1:0]          s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int HI_INT = BASE_ADDR + 4 * NUM_REGS;
  localparam logic [ADDR_WIDTH:0] LO_ADDR = BASE_ADDR[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] HI_ADDR = HI_INT[ADDR_WIDTH:0];
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic in_regs(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= LO_ADDR) && ({1'b0, a} < HI_ADDR) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(({1'b0, a} - LO_ADDR) >> 2);
  endfunction

  function automatic logic is_cnt(input logic [ADDR_WIDTH-1:0] a);
`ifdef AXIL_REG_SLAVE_ERR_CNT_EN
    return {1'b0, a} == HI_ADDR;
`else
    return (a == '1) && (a != a);
`endif
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return in_regs(a) || is_cnt(a);
  endfunction

  // write channel state
  w_state_t                w_state_q, w_state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    aw_got_q, aw_got_d;
  logic                    w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]       w_strb_q, w_strb_d;
  logic                    bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  // read channel state
  r_state_t                r_state_q, r_state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_W-1:0]       wr_strb;
  logic                    unused_strb_msb;

  assign unused_strb_msb = s_axi_wstrb[STRB_W];
  assign aw_hs   = s_axi_awvalid && awready_q;
  assign w_hs    = s_axi_wvalid && wready_q;
  assign ar_hs   = s_axi_arvalid && arready_q && (r_state_q == R_IDLE);
  // A beat arriving on the commit edge is used directly; an earlier one comes from its holding flop.
  assign wr_addr = aw_hs ? s_axi_awaddr : aw_addr_q;
  assign wr_data = w_hs ? s_axi_wdata : w_data_q;
  assign wr_strb = w_hs ? s_axi_wstrb[STRB_W-1:0] : w_strb_q;

`ifdef AXIL_REG_SLAVE_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;

  always_comb begin
    err_sum   = {1'b0, err_cnt_q}
              + 17'(commit && !addr_ok(wr_addr))
              + 17'(ar_hs && !addr_ok(s_axi_araddr));
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    if (commit && is_cnt(wr_addr)) err_cnt_d = '0;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) err_cnt_q <= '0;
    else              err_cnt_q <= err_cnt_d;
  end
`endif

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_got_d = aw_got_q || aw_hs;
        w_got_d  = w_got_q || w_hs;
        if (aw_hs) aw_addr_d = s_axi_awaddr;
        if (w_hs) begin
          w_data_d = s_axi_wdata;
          w_strb_d = s_axi_wstrb[STRB_W-1:0];
        end
        if (aw_got_d && w_got_d) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = addr_ok(wr_addr) ? RESP_OKAY : RESP_DECERR;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          if (in_regs(wr_addr)) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb[b]) regs_d[reg_idx(wr_addr)][b*8 +: 8] = wr_data[b*8 +: 8];
            end
          end
        end else begin
          awready_d = !aw_got_d;
          wready_d  = !w_got_d;
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          // regs_q is the pre-write value, so a same-edge write is not visible here
          rdata_d = '0;
          if (in_regs(s_axi_araddr)) rdata_d = regs_q[reg_idx(s_axi_araddr)];
`ifdef AXIL_REG_SLAVE_ERR_CNT_EN
          if (is_cnt(s_axi_araddr)) rdata_d = DATA_WIDTH'(err_cnt_q);
`endif
          rresp_d   = addr_ok(s_axi_araddr) ? RESP_OKAY : RESP_DECERR;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      regs_q    <= '{default: '0};
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave: expected responses are queued at stimulus time and popped at response time.
module tb_axil_reg_slave;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            areset;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8:0]   wstrb;
  logic [RW-1:0]   bresp, rresp;
  logic [NR*DW-1:0] reg_q;

  axil_reg_slave dut (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_q(reg_q)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
  } rexp_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mdl [NR];
  int unsigned   cnt_mdl;
  logic [RW-1:0] wq [$];
  rexp_t         rq [$];

  function automatic bit in_range(input logic [AW-1:0] a);
    return (a < AW'(4 * NR)) && (a[1:0] == 2'b00);
  endfunction

  function automatic bit is_cnt_addr(input logic [AW-1:0] a);
`ifdef AXIL_REG_SLAVE_ERR_CNT_EN
    return a == AW'(4 * NR);
`else
    return 1'b0 && (a == a);
`endif
  endfunction

  function automatic logic [NR*DW-1:0] exp_regq();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = mdl[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    cnt_mdl = 0;
    wq.delete();
    rq.delete();
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8:0] s);
    if (in_range(a)) begin
      for (int b = 0; b < DW/8; b++)
        if (s[b]) mdl[a >> 2][b*8 +: 8] = d[b*8 +: 8];
      wq.push_back(RW'(0));
    end else if (is_cnt_addr(a)) begin
      cnt_mdl = 0;
      wq.push_back(RW'(0));
    end else begin
      if (cnt_mdl < 32'hFFFF) cnt_mdl++;
      wq.push_back(RW'(3));
    end
  endtask

  task automatic push_read(input logic [AW-1:0] a);
    rexp_t e;
    if (in_range(a)) begin
      e.d = mdl[a >> 2];
      e.r = RW'(0);
    end else if (is_cnt_addr(a)) begin
      e.d = DW'(cnt_mdl);
      e.r = RW'(0);
    end else begin
      e.d = '0;
      e.r = RW'(3);
      if (cnt_mdl < 32'hFFFF) cnt_mdl++;
    end
    rq.push_back(e);
  endtask

  // W is presented w_lead cycles before AW (0 = same edge); returns on the negedge after the last handshake.
  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8:0] s, input int w_lead);
    int  k = 0;
    bit  aw_d = 0, w_d = 0, af, wf;
    push_write(a, d, s);
    awaddr = a; wdata = d; wstrb = s;
    wvalid = 1'b1;
    if (w_lead == 0) awvalid = 1'b1;
    while (!(aw_d && w_d) && k < 50) begin
      af = awvalid && awready;
      wf = wvalid && wready;
      @(negedge clk);
      k++;
      if (af) begin awvalid = 1'b0; aw_d = 1; end
      if (wf) begin wvalid = 1'b0; w_d = 1; end
      if (!aw_d && !awvalid && k >= w_lead) awvalid = 1'b1;
      if (w_d && !aw_d) begin
        checks++;
        if (bvalid !== 1'b0 || wready !== 1'b0) begin
          errors++;
          $display("FAIL w_held got bvalid=%b wready=%b exp bvalid=0 wready=0", bvalid, wready);
        end
      end
    end
    if (!(aw_d && w_d)) begin
      errors++;
      $display("FAIL write_handshake_timeout got aw=%0d w=%0d exp both done", aw_d, w_d);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic take_bresp(input string name);
    int k = 0;
    logic [RW-1:0] e;
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL %s_bvalid_latency got bvalid=%b exp 1", name, bvalid);
    end
    while (bvalid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    e = (wq.size() > 0) ? wq.pop_front() : RW'(7);
    checks++;
    if (bvalid !== 1'b1 || bresp !== e) begin
      errors++;
      $display("FAIL %s_bresp got bvalid=%b bresp=%0d exp bvalid=1 bresp=%0d", name, bvalid, bresp, e);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL %s_after_b got bvalid=%b awready=%b wready=%b exp 0 1 1", name, bvalid, awready, wready);
    end
    $display("write %s bresp=%0d", name, bresp);
  endtask

  task automatic drive_read(input logic [AW-1:0] a, input int hold, input string name);
    int k = 0;
    rexp_t e;
    logic [DW-1:0] first;
    push_read(a);
    araddr = a;
    arvalid = 1'b1;
    while (arready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL %s_rvalid_latency got rvalid=%b exp 1", name, rvalid);
    end
    first = rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== first || arready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold got rvalid=%b rdata=%h arready=%b exp 1 %h 0", name, rvalid, rdata, arready, first);
      end
    end
    e = rq.pop_front();
    checks++;
    if (rdata !== e.d || rresp !== e.r) begin
      errors++;
      $display("FAIL %s_rdata got rdata=%h rresp=%0d exp rdata=%h rresp=%0d", name, rdata, rresp, e.d, e.r);
    end
    $display("read %s addr=%h rdata=%h rresp=%0d", name, a, rdata, rresp);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL %s_after_r got rvalid=%b arready=%b exp 0 1", name, rvalid, arready);
    end
  endtask

  task automatic check_regq(input string name);
    checks++;
    if (reg_q !== exp_regq()) begin
      errors++;
      $display("FAIL %s_reg_q got %h exp %h", name, reg_q, exp_regq());
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    checks++;
    if (awready !== 0 || wready !== 0 || arready !== 0 || bvalid !== 0 || rvalid !== 0 ||
        bresp !== 0 || rresp !== 0 || rdata !== 0 || reg_q !== '0) begin
      errors++;
      $display("FAIL reset_state got aw=%b w=%b ar=%b bv=%b rv=%b br=%0d rr=%0d rd=%h regq=%h exp all 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_q);
    end
    areset = 1'b0;
    @(negedge clk);
    checks++;
    if (awready !== 1 || wready !== 1 || arready !== 1) begin
      errors++;
      $display("FAIL ready_after_reset got aw=%b w=%b ar=%b exp 1 1 1", awready, wready, arready);
    end
    $display("reset done");
  endtask

  task automatic test_write_same_edge();
    drive_write(8'h04, 32'hDEADBEEF, 5'h0F, 0);
    take_bresp("same_edge");
    check_regq("same_edge");
    checks++;
    if (reg_q[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reg1_value got %h exp deadbeef", reg_q[63:32]);
    end
  endtask

  task automatic test_write_w_first();
    drive_write(8'h00, 32'h11223344, 5'h05, 3);
    take_bresp("w_first");
    check_regq("w_first");
    checks++;
    if (reg_q[31:0] !== 32'h00220044) begin
      errors++;
      $display("FAIL reg0_strobe got %h exp 00220044", reg_q[31:0]);
    end
  endtask

  task automatic test_read_backpressure();
    drive_read(8'h04, 4, "backpressure");
  endtask

  task automatic test_decerr();
`ifdef AXIL_REG_SLAVE_ERR_CNT_EN
    drive_write(8'h14, 32'hFFFFFFFF, 5'h1F, 0);
`else
    drive_write(8'h10, 32'hFFFFFFFF, 5'h1F, 0);
`endif
    take_bresp("oob_write");
    check_regq("oob_write");
    drive_read(8'h02, 0, "unaligned_read");
`ifdef AXIL_REG_SLAVE_ERR_CNT_EN
    drive_read(8'h10, 0, "err_cnt");
`endif
    drive_write(8'h06, 32'hFFFFFFFF, 5'h0F, 1);
    take_bresp("unaligned_write");
    check_regq("unaligned_write");
    drive_read(8'h10, 0, "addr_past_end");
    drive_write(8'h10, 32'h0, 5'h0F, 0);
    take_bresp("write_past_end");
    drive_read(8'h10, 0, "after_clear");
  endtask

  task automatic test_same_edge_rw();
    rexp_t e;
    logic [RW-1:0] eb;
    push_read(8'h08);
    push_write(8'h08, 32'hA5A5A5A5, 5'h0F);
    awaddr = 8'h08; wdata = 32'hA5A5A5A5; wstrb = 5'h0F; araddr = 8'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    e = rq.pop_front();
    eb = wq.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== e.d || rresp !== e.r || bvalid !== 1'b1 || bresp !== eb) begin
      errors++;
      $display("FAIL same_edge_rw got rv=%b rdata=%h rresp=%0d bv=%b bresp=%0d exp 1 %h %0d 1 %0d",
               rvalid, rdata, rresp, bvalid, bresp, e.d, e.r, eb);
    end
    $display("same-edge rw rdata=%h bresp=%0d", rdata, bresp);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    drive_read(8'h08, 0, "after_rw");
    check_regq("same_edge_rw");
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] held;
    drive_write(8'h0C, 32'h12345678, 5'h0F, 0);
    held = bresp;
    repeat (2) @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || bresp !== held) begin
      errors++;
      $display("FAIL b_hold got bvalid=%b bresp=%0d exp 1 %0d", bvalid, bresp, held);
    end
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    model_reset();
    checks++;
    if (bvalid !== 1'b0 || reg_q !== '0) begin
      errors++;
      $display("FAIL reset_mid got bvalid=%b reg_q=%h exp 0 0", bvalid, reg_q);
    end
    @(negedge clk);
    drive_write(8'h00, 32'hCAFEF00D, 5'h0F, 0);
    take_bresp("after_reset");
    check_regq("after_reset");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom_range(0, NR - 1) << 2);
      drive_write(a, $urandom, DW/8 + 1'($urandom_range(0, 31)), i % 2);
      take_bresp("b2b");
    end
    drive_write(8'h04, 32'h0BADF00D, 5'h10, 0);
    take_bresp("zero_strb");
    check_regq("back_to_back");
    for (int i = 0; i < NR; i++) drive_read(AW'(i * 4), i % 3, "b2b_read");
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_same_edge();
    test_write_w_first();
    test_read_backpressure();
    test_decerr();
    test_same_edge_rw();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
